// File: rtl/pcie_ingress_buf_ctrl.sv
// Ping-pong A/B buffer scheduler for the PCIe ingress completion path: splits a
// transfer into buffer-sized chunks, issues host reads, tracks fills, hands buffers on.
module pcie_ingress_buf_ctrl #(
  parameter int BUF_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_xfer_start,
  input  logic [31:0]       i_xfer_dword_count,
  input  logic [31:0]       i_buffer_size,
  output logic              o_rd_req_stb,
  output logic              o_rd_req_buf,
  output logic [31:0]       o_rd_req_dword_count,
  input  logic              i_rd_req_ack,
  output logic [31:0]       o_buf_offset,
  output logic              o_buf_rdy,
  input  logic              i_buf_we,
  input  logic [31:0]       i_buf_addr,
  output logic              o_cons_valid,
  output logic              o_cons_sel,
  output logic [BUF_AW:0]   o_cons_count,
  input  logic              i_cons_done,
  output logic              o_busy,
  output logic              o_done_stb,
  output logic              o_addr_err
);

  localparam int CW = BUF_AW + 1;
  localparam logic [CW-1:0] BUF_DW = {1'b1, {BUF_AW{1'b0}}};

  typedef enum logic [2:0] {IDLE, REQUEST, FILL, WAIT_FREE, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   remaining, rem_after, buf_offset;
  logic [CW-1:0] chunk, fill_cnt, size_c;
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    filled, filled_post, fill_set;
  logic          fill_sel, cons_sel, done_stb, addr_err;
  logic          release_c, start_acc, abort, wr, fill_last, addr_bad;

  function automatic logic [CW-1:0] min_chunk(input logic [31:0] rem, input logic [CW-1:0] sz);
    return (rem < 32'(sz)) ? rem[CW-1:0] : sz;
  endfunction

  // Zero or oversized chunk requests fall back to a full buffer.
  assign size_c = (i_buffer_size == 32'd0 || i_buffer_size > 32'(BUF_DW)) ? BUF_DW
                                                                          : i_buffer_size[CW-1:0];

  assign release_c   = i_cons_done & filled[cons_sel];
  assign filled_post = filled & ~(release_c ? (2'b01 << cons_sel) : 2'b00);
  assign start_acc   = (state == IDLE) & i_xfer_start & i_enable;
  assign abort       = (state != IDLE) & ~i_enable;
  assign wr          = (state == FILL) & i_buf_we & ~abort;
  assign fill_last   = wr & ((fill_cnt + CW'(1)) == chunk);
  assign fill_set    = fill_last ? (2'b01 << fill_sel) : 2'b00;
  assign rem_after   = remaining - 32'(chunk);
  assign addr_bad    = (i_buf_addr < buf_offset) || (i_buf_addr >= buf_offset + 32'(chunk));

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_acc && i_xfer_dword_count != 32'd0) state_nxt = REQUEST;
      REQUEST:   if (i_rd_req_ack) state_nxt = FILL;
      FILL: begin
        if (fill_last) begin
          if (rem_after == 32'd0)        state_nxt = DRAIN;
          else if (filled_post[~fill_sel]) state_nxt = WAIT_FREE;
          else                           state_nxt = REQUEST;
        end
      end
      WAIT_FREE: if (!filled_post[fill_sel]) state_nxt = REQUEST;
      DRAIN:     if (filled == 2'b00) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining  <= '0;
      chunk      <= '0;
      fill_cnt   <= '0;
      buf_offset <= '0;
      filled     <= '0;
      fill_sel   <= 1'b0;
      cons_sel   <= 1'b0;
      done_stb   <= 1'b0;
      addr_err   <= 1'b0;
      // NOTE: the per-buffer counts are two flops, not a RAM, so they are reset like any register.
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      filled   <= abort ? 2'b00 : (filled_post | fill_set);
      done_stb <= (start_acc && i_xfer_dword_count == 32'd0) ||
                  (state == DRAIN && filled == 2'b00 && !abort);
      if (release_c) cons_sel <= ~cons_sel;

      if (start_acc && i_xfer_dword_count != 32'd0) begin
        remaining <= i_xfer_dword_count;
        chunk     <= min_chunk(i_xfer_dword_count, size_c);
        fill_sel  <= 1'b0;
        cons_sel  <= 1'b0;
        addr_err  <= 1'b0;
      end

      if (state == REQUEST && i_rd_req_ack && !abort) begin
        fill_cnt   <= '0;
        buf_offset <= fill_sel ? 32'(BUF_DW) : 32'd0;
      end

      if (wr) begin
        fill_cnt <= fill_cnt + CW'(1);
        if (addr_bad) addr_err <= 1'b1;
      end

      // Chunk complete: publish the buffer and line up the next chunk on the other one.
      if (fill_last) begin
        cnt_q[fill_sel] <= chunk;
        remaining       <= rem_after;
        if (rem_after != 32'd0) begin
          fill_sel <= ~fill_sel;
          chunk    <= min_chunk(rem_after, size_c);
        end
      end
    end
  end

  assign o_rd_req_stb         = (state == REQUEST);
  assign o_rd_req_buf         = (state == REQUEST) & fill_sel;
  assign o_rd_req_dword_count = (state == REQUEST) ? 32'(chunk) : 32'd0;
  assign o_buf_offset         = buf_offset;
  assign o_buf_rdy            = (state == FILL);
  assign o_cons_valid         = filled[cons_sel];
  assign o_cons_sel           = cons_sel;
  assign o_cons_count         = cnt_q[cons_sel];
  assign o_busy               = (state != IDLE);
  assign o_done_stb           = done_stb;
  assign o_addr_err           = addr_err;

endmodule

// File: tb/tb_pcie_ingress_buf_ctrl.sv
// Self-checking bench for pcie_ingress_buf_ctrl: directed and randomized transfers
// checked against a chunk-list model built from the transfer size rules.
module tb_pcie_ingress_buf_ctrl;

  localparam int BUF_AW = 10;
  localparam int BUF_DW = 1 << BUF_AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_enable, i_xfer_start, i_rd_req_ack, i_buf_we, i_cons_done;
  logic [31:0]       i_xfer_dword_count, i_buffer_size, i_buf_addr;
  logic              o_rd_req_stb, o_rd_req_buf, o_buf_rdy, o_cons_valid, o_cons_sel;
  logic              o_busy, o_done_stb, o_addr_err;
  logic [31:0]       o_rd_req_dword_count, o_buf_offset;
  logic [BUF_AW:0]   o_cons_count;

  pcie_ingress_buf_ctrl #(.BUF_AW(BUF_AW)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_xfer_start(i_xfer_start),
    .i_xfer_dword_count(i_xfer_dword_count), .i_buffer_size(i_buffer_size),
    .o_rd_req_stb(o_rd_req_stb), .o_rd_req_buf(o_rd_req_buf),
    .o_rd_req_dword_count(o_rd_req_dword_count), .i_rd_req_ack(i_rd_req_ack),
    .o_buf_offset(o_buf_offset), .o_buf_rdy(o_buf_rdy), .i_buf_we(i_buf_we),
    .i_buf_addr(i_buf_addr), .o_cons_valid(o_cons_valid), .o_cons_sel(o_cons_sel),
    .o_cons_count(o_cons_count), .i_cons_done(i_cons_done), .o_busy(o_busy),
    .o_done_stb(o_done_stb), .o_addr_err(o_addr_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int done_cnt = 0;
  int chunk_idx = 0;
  int ack_delay_max = 0;
  bit cons_auto = 1'b0;
  bit exp_sel = 1'b0;
  int plan_len[$];
  int exp_cons[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Model: the transfer becomes a list of min(clamped size, remaining) chunks, alternating A/B.
  task automatic start_xfer(input int unsigned count, input int unsigned size);
    int unsigned sz, rem, c;
    sz  = (size == 0 || size > BUF_DW) ? BUF_DW : size;
    rem = count;
    plan_len.delete();
    exp_cons.delete();
    while (rem > 0) begin
      c = (rem < sz) ? rem : sz;
      plan_len.push_back(int'(c));
      exp_cons.push_back(int'(c));
      rem -= c;
    end
    chunk_idx = 0;
    exp_sel   = 1'b0;
    i_xfer_dword_count = count;
    i_buffer_size      = size;
    i_xfer_start = 1'b1;
    tick();
    i_xfer_start = 1'b0;
    check("start_busy", o_busy, 1);
    check("start_err_clr", o_addr_err, 0);
  endtask

  task automatic cons_check();
    if (exp_cons.size() == 0) begin
      check("cons_extra", 1, 0);
    end else begin
      check("cons_count", o_cons_count, exp_cons.pop_front());
      check("cons_sel", o_cons_sel, exp_sel);
      exp_sel = ~exp_sel;
    end
  endtask

  // Serve one chunk: wait for its request, ack it, then write stop_at dwords (<0 = all).
  task automatic serve_chunk(input int bad_idx, input int stop_at);
    int len, nwr, t;
    bit b;
    logic [31:0] base;
    len = plan_len.pop_front();
    b   = chunk_idx[0];
    chunk_idx++;
    base = b ? 32'(BUF_DW) : 32'd0;
    t = 0;
    while (!o_rd_req_stb && t < 2000) begin tick(); t++; end
    check("req_timeout", (t >= 2000), 0);
    check("req_buf", o_rd_req_buf, b);
    check("req_len", o_rd_req_dword_count, len);
    repeat ($urandom_range(0, ack_delay_max)) tick();
    check("req_hold", {o_rd_req_stb, o_rd_req_buf}, {1'b1, b});
    i_rd_req_ack = 1'b1;
    tick();
    i_rd_req_ack = 1'b0;
    check("req_drop", o_rd_req_stb, 0);
    check("buf_rdy", o_buf_rdy, 1);
    check("buf_offset", o_buf_offset, base);
    nwr = (stop_at < 0) ? len : stop_at;
    for (int k = 0; k < nwr; k++) begin
      while ($urandom_range(0, 3) == 0) tick();
      i_buf_we   = 1'b1;
      i_buf_addr = (k == bad_idx) ? (base ^ 32'(BUF_DW)) : base + 32'(k);
      tick();
      i_buf_we = 1'b0;
    end
    if (stop_at < 0) check("rdy_drop", o_buf_rdy, 0);
  endtask

  task automatic finish_xfer();
    int d0, t;
    d0 = done_cnt;
    t = 0;
    while (!o_done_stb && t < 5000) begin tick(); t++; end
    check("done_timeout", (t >= 5000), 0);
    repeat (3) tick();
    check("done_once", done_cnt, d0 + 1);
    check("end_idle", {o_busy, o_cons_valid}, 0);
    check("all_consumed", exp_cons.size(), 0);
  endtask

  task automatic run_xfer(input int unsigned count, input int unsigned size);
    int n;
    start_xfer(count, size);
    n = plan_len.size();
    for (int i = 0; i < n; i++) serve_chunk(-1, -1);
    finish_xfer();
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    i_enable = 1'b1; i_xfer_start = 1'b0; i_rd_req_ack = 1'b0; i_buf_we = 1'b0;
    i_cons_done = 1'b0; i_xfer_dword_count = '0; i_buffer_size = '0; i_buf_addr = '0;

    fork
      forever begin
        @(negedge clk);
        if (o_done_stb) done_cnt++;
      end
      forever begin
        @(negedge clk);
        if (cons_auto && o_cons_valid) begin
          tick();
          cons_check();
          i_cons_done = 1'b1;
          tick();
          i_cons_done = 1'b0;
        end
      end
    join_none

    repeat (3) tick();
    check("rst_flags", {o_rd_req_stb, o_rd_req_buf, o_buf_rdy, o_cons_valid, o_cons_sel,
                        o_busy, o_done_stb, o_addr_err}, 0);
    rst = 1'b0;
    tick();
    check("rst_vals", o_rd_req_dword_count | o_buf_offset | 32'(o_cons_count), 0);

    // Zero-length transfer: done pulse next cycle, no state change.
    i_xfer_dword_count = 0; i_xfer_start = 1'b1;
    tick();
    i_xfer_start = 1'b0;
    check("zero_done", {o_done_stb, o_busy}, 2'b10);
    tick();
    check("zero_done_pulse", o_done_stb, 0);

    // Start with enable low is ignored.
    i_enable = 1'b0; i_xfer_dword_count = 100; i_xfer_start = 1'b1;
    tick();
    i_xfer_start = 1'b0;
    tick();
    check("start_dis", {o_busy, o_done_stb}, 0);
    i_enable = 1'b1;

    cons_auto = 1'b1;
    run_xfer(2048, 512);
    run_xfer(1300, 0);
    ack_delay_max = 3;
    for (int r = 0; r < 4; r++) run_xfer($urandom_range(1, 2500), $urandom_range(0, 1500));
    ack_delay_max = 0;

    // Consumer stall: both buffers full, third request waits for A's release.
    cons_auto = 1'b0;
    start_xfer(3072, 1024);
    serve_chunk(-1, -1);
    serve_chunk(-1, -1);
    repeat (4) tick();
    check("stall_flags", {o_busy, o_buf_rdy, o_rd_req_stb, o_cons_valid, o_cons_sel}, 5'b10010);
    cons_check();
    i_cons_done = 1'b1;
    tick();
    i_cons_done = 1'b0;
    check("stall_req", {o_rd_req_stb, o_rd_req_buf}, 2'b10);
    cons_auto = 1'b1;
    serve_chunk(-1, -1);
    finish_xfer();

    // Fill of B completes in the same cycle that A is released.
    cons_auto = 1'b0;
    start_xfer(768, 256);
    serve_chunk(-1, -1);
    serve_chunk(-1, 255);
    check("simul_valid", o_cons_valid, 1);
    cons_check();
    i_buf_we = 1'b1; i_buf_addr = 32'(BUF_DW + 255); i_cons_done = 1'b1;
    tick();
    i_buf_we = 1'b0; i_cons_done = 1'b0;
    check("simul_req", {o_rd_req_stb, o_rd_req_buf}, 2'b10);
    cons_auto = 1'b1;
    serve_chunk(-1, -1);
    finish_xfer();

    // Out-of-chunk write sets a sticky error, cleared by the next start.
    start_xfer(1024, 512);
    serve_chunk(5, -1);
    check("err_set", o_addr_err, 1);
    serve_chunk(-1, -1);
    finish_xfer();
    check("err_sticky", o_addr_err, 1);
    run_xfer(16, 512);

    // Enable dropped mid-FILL.
    d0 = done_cnt;
    start_xfer(2048, 512);
    serve_chunk(-1, 100);
    i_enable = 1'b0;
    tick();
    check("abort_outs", {o_busy, o_buf_rdy, o_rd_req_stb, o_cons_valid}, 0);
    i_enable = 1'b1;
    repeat (5) tick();
    check("abort_no_done", done_cnt, d0);
    exp_cons.delete();
    run_xfer(16, 512);

    // Asynchronous reset mid-REQUEST.
    d0 = done_cnt;
    start_xfer(2048, 512);
    check("pre_rst_req", o_rd_req_stb, 1);
    #2 rst = 1'b1;
    #1 check("rst_async", {o_rd_req_stb, o_rd_req_buf, o_buf_rdy, o_cons_valid,
                           o_busy, o_done_stb, o_addr_err}, 0);
    check("rst_async_vals", o_rd_req_dword_count | o_buf_offset | 32'(o_cons_count), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rst_no_done", done_cnt, d0);
    exp_cons.delete();
    run_xfer(16, 512);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
